// File: rtl/snake_body_store_pkg.sv
// Shared widths, defaults, FSM encoding and coordinate type for the snake body store.
package snake_pkg;

  localparam int unsigned XW           = 8;
  localparam int unsigned YW           = 7;
  localparam int unsigned MAX_LEN_DFLT = 16;
  localparam int unsigned SEG_DFLT     = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } coord_t;

endpackage

// File: rtl/snake_body_store_if.sv
// Step/read/status bundle between the game controller (master) and the body store (slave).
interface snake_body_store_if
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DFLT,
  parameter int unsigned LW      = $clog2(MAX_LEN)
) ();

  logic          step;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          grow;
  logic [LW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_valid;
  logic [LW:0]   length;
  logic [XW-1:0] tail_x;
  logic [YW-1:0] tail_y;
  logic          tail_valid;
  logic          busy;
  logic          done;
  logic          hit_self;

  modport master (
    output step, head_x, head_y, grow, rd_idx,
    input  rd_x, rd_y, rd_valid, length, tail_x, tail_y, tail_valid, busy, done, hit_self
  );

  modport slave (
    input  step, head_x, head_y, grow, rd_idx,
    output rd_x, rd_y, rd_valid, length, tail_x, tail_y, tail_valid, busy, done, hit_self
  );

endinterface

// File: rtl/snake_body_store_seg_shift_reg.sv
// Parallel-load segment shift register with reset-time body pattern,
// a registered indexed read port and combinational scan/head/tail taps.
module seg_shift_reg
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH    = MAX_LEN_DFLT,
  parameter int unsigned INIT_LEN = 2,
  parameter int unsigned X0       = 39,
  parameter int unsigned Y0       = 59,
  parameter int unsigned SEG      = SEG_DFLT,
  parameter int unsigned LW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift,
  input  coord_t        din,
  input  logic [LW:0]   length,
  input  logic [LW-1:0] rd_idx,
  input  logic [LW-1:0] scan_idx,
  output coord_t        rd_data,
  output logic          rd_valid,
  output coord_t        scan_c,
  output coord_t        head_c,
  output coord_t        tail_c
);

  localparam int unsigned LENW = LW + 1;

  coord_t mem [DEPTH];

  function automatic coord_t init_seg(input int unsigned i);
    coord_t c;
    c.x = XW'(X0 - i * SEG);
    c.y = YW'(Y0);
    return c;
  endfunction

  // Body storage: index 0 is the head, shifting pushes everything one slot tailward.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < INIT_LEN) ? init_seg(i) : '0;
      end
    end else if (shift) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Read sees the pre-shift contents and the pre-update length.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (LENW'(rd_idx) < length) begin
      rd_data  <= mem[rd_idx];
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end
  end

  assign scan_c = mem[scan_idx];
  assign head_c = mem[0];
  assign tail_c = mem[LW'(length - LENW'(1))];

endmodule

// File: rtl/snake_body_store.sv
// Snake segment store: shifts in each new head, reports the dropped tail,
// then scans the body for a self-collision before pulsing done.
module snake_body_store
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DFLT,
  parameter int unsigned INIT_LEN = 2,
  parameter int unsigned X0       = 39,
  parameter int unsigned Y0       = 59,
  parameter int unsigned SEG      = SEG_DFLT
) (
  input logic               clk,
  input logic               reset,
  snake_body_store_if.slave bus
);

  localparam int unsigned LW   = $clog2(MAX_LEN);
  localparam int unsigned LENW = LW + 1;

  if (INIT_LEN < 1 || INIT_LEN > MAX_LEN || X0 < (INIT_LEN - 1) * SEG) begin : g_bad_init
    $error("snake_body_store: initial body does not fit (INIT_LEN/X0/SEG)");
  end

  logic [1:0]    state_q, state_d;
  logic [LENW-1:0] length_q, length_d;
  logic [LW-1:0] k_q, k_d;
  logic          grow_pend_q, grow_pend_d;
  logic          hit_q, hit_d;
  logic          accept_c, grow_ok_c, grow_eff_c;
  logic [XW-1:0] tail_x_q;
  logic [YW-1:0] tail_y_q;
  logic          tail_valid_q, busy_q, done_q;

  coord_t head_new_c, rd_seg, scan_seg_c, head_seg_c, tail_seg_c;

  assign head_new_c = '{x: bus.head_x, y: bus.head_y};

  seg_shift_reg #(
    .DEPTH    (MAX_LEN),
    .INIT_LEN (INIT_LEN),
    .X0       (X0),
    .Y0       (Y0),
    .SEG      (SEG),
    .LW       (LW)
  ) u_body (
    .clk      (clk),
    .reset    (reset),
    .shift    (accept_c),
    .din      (head_new_c),
    .length   (length_q),
    .rd_idx   (bus.rd_idx),
    .scan_idx (k_q),
    .rd_data  (rd_seg),
    .rd_valid (bus.rd_valid),
    .scan_c   (scan_seg_c),
    .head_c   (head_seg_c),
    .tail_c   (tail_seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus next values of length, scan index, grow_pend and hit_self.
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    grow_eff_c  = grow_pend_q | bus.grow;
    grow_ok_c   = grow_eff_c && (length_q < LENW'(MAX_LEN));
    grow_pend_d = grow_eff_c;
    length_d    = length_q;
    k_d         = k_q;
    hit_d       = hit_q;
    case (state_q)
      IDLE: begin
        if (bus.step) begin
          accept_c    = 1'b1;
          grow_pend_d = 1'b0;
          k_d         = LW'(1);
          if (grow_ok_c) length_d = length_q + LENW'(1);
          state_d = (length_d > LENW'(1)) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (scan_seg_c == head_seg_c) hit_d = 1'b1;
        k_d = k_q + LW'(1);
        if (LENW'(k_q) == length_q - LENW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      length_q     <= LENW'(INIT_LEN);
      k_q          <= '0;
      grow_pend_q  <= 1'b0;
      hit_q        <= 1'b0;
      tail_x_q     <= '0;
      tail_y_q     <= '0;
      tail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      length_q    <= length_d;
      k_q         <= k_d;
      grow_pend_q <= grow_pend_d;
      hit_q       <= hit_d;
      busy_q      <= (state_d == SCAN);
      done_q      <= (state_q == DONE);
      if (accept_c) begin
        tail_x_q     <= tail_seg_c.x;
        tail_y_q     <= tail_seg_c.y;
        tail_valid_q <= ~grow_ok_c;
      end
    end
  end

  assign bus.rd_x       = rd_seg.x;
  assign bus.rd_y       = rd_seg.y;
  assign bus.length     = length_q;
  assign bus.tail_x     = tail_x_q;
  assign bus.tail_y     = tail_y_q;
  assign bus.tail_valid = tail_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hit_self   = hit_q;

endmodule

// File: tb/tb_snake_body_store.sv
// Directed self-checking bench for snake_body_store with hand-computed expectations.
module tb_snake_body_store;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  snake_body_store_if bus ();

  snake_body_store dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int idx, input int ex, input int ey, input int ev);
    bus.rd_idx = 4'(idx);
    @(negedge clk);
    chk({tag, ".x"}, 32'(bus.rd_x), 32'(ex));
    chk({tag, ".y"}, 32'(bus.rd_y), 32'(ey));
    chk({tag, ".v"}, 32'(bus.rd_valid), 32'(ev));
  endtask

  task automatic wait_done(input string tag, input int start, input int exp_lat);
    int cyc;
    cyc = start;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic step_wait(input string tag, input int x, input int y, input logic g, input int exp_lat);
    bus.step   = 1'b1;
    bus.head_x = 8'(x);
    bus.head_y = 7'(y);
    bus.grow   = g;
    @(negedge clk);
    bus.step = 1'b0;
    bus.grow = 1'b0;
    wait_done(tag, 1, exp_lat);
  endtask

  task automatic tail_chk(input string tag, input int tx, input int ty, input int tv, input int len);
    chk({tag, ".tail_x"}, 32'(bus.tail_x), 32'(tx));
    chk({tag, ".tail_y"}, 32'(bus.tail_y), 32'(ty));
    chk({tag, ".tail_valid"}, 32'(bus.tail_valid), 32'(tv));
    chk({tag, ".length"}, 32'(bus.length), 32'(len));
  endtask

  initial begin
    int extra;
    reset      = 1'b1;
    bus.step   = 1'b0;
    bus.grow   = 1'b0;
    bus.head_x = '0;
    bus.head_y = '0;
    bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    chk("rst.length", 32'(bus.length), 32'd2);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.hit", 32'(bus.hit_self), 32'd0);
    chk("rst.rd_x", 32'(bus.rd_x), 32'd0);
    tail_chk("rst", 0, 0, 0, 2);
    reset = 1'b0;

    rd_chk("init0", 0, 39, 59, 1);
    rd_chk("init1", 1, 29, 59, 1);
    rd_chk("init2", 2, 0, 0, 0);

    // plain move: body (49,59),(39,59)
    step_wait("mv1", 49, 59, 1'b0, 3);
    tail_chk("mv1", 29, 59, 1, 2);
    chk("mv1.hit", 32'(bus.hit_self), 32'd0);

    // standalone grow pulse, consumed by the following step
    bus.grow = 1'b1;
    @(negedge clk);
    bus.grow = 1'b0;
    step_wait("grow", 59, 59, 1'b0, 4);
    tail_chk("grow", 39, 59, 0, 3);
    chk("grow.hit", 32'(bus.hit_self), 32'd0);
    rd_chk("grow0", 0, 59, 59, 1);
    rd_chk("grow1", 1, 49, 59, 1);
    rd_chk("grow2", 2, 39, 59, 1);

    // head onto own body: (49,59),(59,59),(49,59)
    step_wait("hit", 49, 59, 1'b0, 4);
    tail_chk("hit", 39, 59, 1, 3);
    chk("hit.hit", 32'(bus.hit_self), 32'd1);

    // second step while scanning must be dropped
    bus.step   = 1'b1;
    bus.head_x = 8'd10;
    bus.head_y = 7'd20;
    @(negedge clk);
    chk("busy.busy", 32'(bus.busy), 32'd1);
    bus.head_x = 8'd99;
    bus.head_y = 7'd99;
    @(negedge clk);
    bus.step = 1'b0;
    wait_done("busy", 2, 4);
    tail_chk("busy", 49, 59, 1, 3);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    chk("busy.extra_done", 32'(extra), 32'd0);
    chk("busy.len_after", 32'(bus.length), 32'd3);
    rd_chk("busy0", 0, 10, 20, 1);
    rd_chk("busy1", 1, 49, 59, 1);
    rd_chk("busy2", 2, 59, 59, 1);
    chk("busy.hit_sticky", 32'(bus.hit_self), 32'd1);

    // fill to the maximum with grow+step in the same cycle
    for (int i = 0; i < 13; i++) begin
      step_wait("fill", 100 + i, i, 1'b1, 5 + i);
    end
    chk("fill.length", 32'(bus.length), 32'd16);
    chk("fill.tail_valid", 32'(bus.tail_valid), 32'd0);

    step_wait("max", 120, 5, 1'b1, 17);
    tail_chk("max", 59, 59, 1, 16);
    chk("max.hit", 32'(bus.hit_self), 32'd1);
    rd_chk("max0", 0, 120, 5, 1);
    rd_chk("max15", 15, 49, 59, 1);

    // reset in the middle of a long scan
    bus.step   = 1'b1;
    bus.head_x = 8'd7;
    bus.head_y = 7'd7;
    @(negedge clk);
    bus.step = 1'b0;
    chk("midrst.busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    chk("midrst.hit", 32'(bus.hit_self), 32'd0);
    tail_chk("midrst", 0, 0, 0, 2);
    reset = 1'b0;
    rd_chk("midrst0", 0, 39, 59, 1);
    rd_chk("midrst1", 1, 29, 59, 1);
    rd_chk("midrst2", 2, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
